pulse_sync_issuer_3bit: RTL
===========================

# pulse_sync_issuer_3bit

Fast-domain (clk_a side) issuer for the 3-bit pulse synchronizer. It accepts event pulses on any clock cycle, counts pending events per bit, and forwards them as single-cycle pulses into the synchronizer only when the synchronizer's `busy` is low. This ensures no pulse is dropped while the crossing handshake is in flight. It sits between the logical-layer event sources and the synchronizer's `sig_3bit` input, with the synchronizer's `busy` fed back.

## Interface
- `GUARD_CYC`, default 3: cycles after an issue during which `busy` is ignored, covering the synchronizer's busy-assert latency. Legal range is 1..15.
- `clk`  input  1  fast clock (same clock as the synchronizer's fast side).
- `rst`  input  1  asynchronous, active-low reset.
- `ev_3bit`  input  3  event pulses; each high cycle is one event per bit.
- `busy`  input  1  busy from the synchronizer (OR of all bits).
- `sig_3bit`  output  3  registered single-cycle pulses to the synchronizer.
- `pending_3bit`  output  3  per bit, high while that bit's pending count is nonzero.
- `ovf`  output  1  sticky flag: an event was lost to saturation.
- `ovf_clr`  input  1  synchronous clear of `ovf`.

## Operation
- **Reset** (`rst`=0, asynchronous): state IDLE, all counts 0, guard counter 0. `sig_3bit`=0, `pending_3bit`=0, `ovf`=0.
- **Per-bit pending count** `cnt[i]`, 2 bits, range 0..3:
  - Increments on `ev_3bit[i]`.
  - Decrements when bit i is issued.
  - Event and issue in the same cycle leave the count unchanged.
  - An event at count 3 with no issue that cycle saturates at 3 and is lost (see Configuration).
- **FSM states:**
  - IDLE: if `busy`=0 and any `cnt`≠0, the next edge:
    - registers `sig_3bit[i]` = (`cnt[i]`≠0) for all bits simultaneously;
    - decrements those counts;
    - loads the guard counter with `GUARD_CYC`;
    - moves to GUARD.
    - Otherwise stay in IDLE with `sig_3bit`=0.
  - GUARD: `sig_3bit` = 0. Guard counter decrements each cycle, with `busy` ignored. On reaching 0, go to WAIT.
  - WAIT: `sig_3bit` = 0. When `busy`=0, go to IDLE. No timeout.
- `sig_3bit` is never high in two consecutive cycles. At most one issue occurs per IDLE→GUARD→WAIT round.
- `pending_3bit[i]` = (`cnt[i]`≠0), registered with the count.
- `ovf_clr` and a saturation loss in the same cycle: `ovf` ends at 1 (set wins).
- Events arriving in GUARD or WAIT accumulate; they are issued at the next IDLE with `busy`=0.

## Timing
- Event high in cycle n, with FSM in IDLE and `busy`=0:
  - `cnt` is 1 in cycle n+1;
  - `sig_3bit` is high in cycle n+2 for exactly one cycle;
  - `cnt` returns to 0 in cycle n+3.
- Issue-to-issue minimum spacing is `GUARD_CYC`+2 cycles: GUARD for `GUARD_CYC` cycles, plus one WAIT cycle, plus one IDLE cycle.
- `busy` is sampled only in IDLE and WAIT. A `busy` glitch during GUARD has no effect.
- Reset asserted mid-round: immediate return to IDLE. Pending counts are discarded and any `sig_3bit` pulse in progress is cut.

## Configuration
- Macro `PULSE_SYNC_ISSUER_OVF_EN`:
  - **Defined:** `ovf` operates as described, and `ovf_clr` is honoured.
  - **Not defined:** `ovf` is tied to 0, `ovf_clr` is ignored, and saturation loss is silent. Count behaviour is identical in both builds.

## Test plan
- **Single event:** `ev_3bit`=3'b010 for one cycle with `busy`=0.
  - Expect `sig_3bit`=3'b010 exactly 2 cycles later, for 1 cycle.
  - Expect `pending_3bit[1]` high for exactly 2 cycles (n+1, n+2).
- **Issue blocked by busy:** hold `busy`=1, pulse `ev_3bit`=3'b001 three times, then drop `busy`.
  - Expect three `sig_3bit[0]` pulses, the first 1 cycle after `busy` falls.
  - Consecutive pulses are ≥5 cycles apart (`GUARD_CYC`=3), with `busy` held 0 throughout.
- **Simultaneous bits:** events on bits 0 and 2 in the same cycle.
  - Expect one issue with `sig_3bit`=3'b101.
  - Event on bit 1 one cycle later is issued in the next round only.
- **Saturation:** with `busy`=1, pulse bit 0 five times.
  - Expect `cnt`=3, `ovf`=1 (macro defined), and exactly 3 pulses issued after `busy` drops.
  - `ovf_clr` then clears `ovf` to 0.
  - Without the macro, `ovf` stays 0.
- **Event coincident with issue:** with `cnt[0]`=1, issue in progress, assert `ev_3bit[0]` on the issue edge.
  - Expect `cnt[0]` to remain 1 and a second pulse in the next round.
- **Reset mid-round:** assert `rst`=0 during GUARD with `cnt`=2.
  - Expect all outputs 0 immediately, and no pulses after `rst` rises until a new event arrives.

Source files
------------

// File: rtl/pulse_sync_issuer_3bit.sv
// Fast-side issuer: queues up to 3 events per bit, issues them as 1-cycle pulses when busy is low.
// Event->pulse 2 cycles; issues spaced GUARD_CYC+2 apart; PULSE_SYNC_ISSUER_OVF_EN enables sticky ovf.
module pulse_sync_issuer_3bit #(
    parameter int unsigned GUARD_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ev_3bit,
    input  logic       busy,
    input  logic       ovf_clr,
    output logic [2:0] sig_3bit,
    output logic [2:0] pending_3bit,
    output logic       ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] GUARD_LD = 4'(GUARD_CYC);

    state_t          r_state;
    logic [3:0]      r_guard;
    logic [2:0]      r_sig;
    logic [2:0][1:0] r_cnt;

    logic [2:0]      w_nz;
    logic [2:0]      w_lost;
    logic [2:0][1:0] w_cnt_nxt;
    logic            w_any;

    // A bit is "issued" while its pulse is on the wire, so the count drops
    // in the pulse cycle; an event in that same cycle cancels the drop.
    always_comb begin
        w_nz      = '0;
        w_lost    = '0;
        w_cnt_nxt = r_cnt;
        for (int i = 0; i < 3; i++) begin
            w_nz[i] = (r_cnt[i] != 2'd0);
            if (r_sig[i] && !ev_3bit[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - 2'd1;
            end else if (ev_3bit[i] && !r_sig[i]) begin
                if (r_cnt[i] == 2'd3) begin
                    w_lost[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign w_any = |w_nz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_guard <= 4'd0;
            r_sig   <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!busy && w_any) begin
                        r_sig   <= w_nz;
                        r_guard <= GUARD_LD;
                        r_state <= ST_GUARD;
                    end else begin
                        r_sig <= 3'b000;
                    end
                end
                // busy is deliberately ignored here: the synchronizer has not
                // yet had time to raise it for the pulse just sent.
                ST_GUARD: begin
                    r_sig <= 3'b000;
                    if (r_guard <= 4'd1) begin
                        r_guard <= 4'd0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_guard <= r_guard - 4'd1;
                    end
                end
                ST_WAIT: begin
                    r_sig <= 3'b000;
                    if (!busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_sig   <= 3'b000;
                    r_guard <= 4'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sig_3bit     = r_sig;
    assign pending_3bit = w_nz;

`ifdef PULSE_SYNC_ISSUER_OVF_EN
    logic r_ovf;

    // Set wins over a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (|w_lost) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = ovf_clr ^ (|w_lost);
    assign ovf          = 1'b0;
`endif

endmodule
